// File: rtl/atm_session_ctrl.sv
// ATM session controller: PIN check with retry limit, balance query, withdrawal
// with dispense handshake, inactivity timeout and timed or permanent lockout.
module atm_session_ctrl #(
    parameter int PIN_W       = 16,
    parameter int AMT_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT     = 30,
    parameter int LOCK_CYCLES = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             insert_card,
    input  logic [PIN_W-1:0] card_pin,
    input  logic [AMT_W-1:0] card_balance,
    input  logic [PIN_W-1:0] pin_input,
    input  logic             pin_valid,
    input  logic             balance_check,
    input  logic             withdraw,
    input  logic [AMT_W-1:0] amount,
    input  logic             amount_entered,
    input  logic             cash_taken,
    input  logic             exit,
    output logic [2:0]       state,
    output logic             auth_success,
    output logic             freeze,
    output logic [3:0]       tries_left,
    output logic [AMT_W-1:0] balance,
    output logic             bal_valid,
    output logic             dispense,
    output logic [AMT_W-1:0] dispense_amt,
    output logic             insufficient,
    output logic             timeout
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PIN      = 3'd1,
        S_MENU     = 3'd2,
        S_BALANCE  = 3'd3,
        S_WITHDRAW = 3'd4,
        S_DISPENSE = 3'd5,
        S_LOCKED   = 3'd6,
        S_EJECT    = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [AMT_W-1:0] bal_q, bal_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [3:0]       tries_q, tries_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic [LW-1:0]    lock_q, lock_d;
    logic             insuf_q, insuf_d;
    logic             tmo_q, tmo_d;
    logic             active, strobe, expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pin_q   <= '0;
            bal_q   <= '0;
            amt_q   <= '0;
            tries_q <= '0;
            idle_q  <= '0;
            lock_q  <= '0;
            insuf_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            bal_q   <= bal_d;
            amt_q   <= amt_d;
            tries_q <= tries_d;
            idle_q  <= idle_d;
            lock_q  <= lock_d;
            insuf_q <= insuf_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        bal_d   = bal_q;
        amt_d   = amt_q;
        tries_d = tries_q;
        idle_d  = '0;
        lock_d  = '0;
        insuf_d = 1'b0;
        tmo_d   = 1'b0;
        active  = state_q inside {S_PIN, S_MENU, S_WITHDRAW, S_DISPENSE};
        strobe  = pin_valid | withdraw | balance_check | amount_entered | exit;
        // idle_q holds the number of quiet cycles already spent; expiry wins over any input
        expire  = active && (idle_q == TW'(TIMEOUT - 1));

        if (expire) begin
            state_d = S_EJECT;
            tmo_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (insert_card) begin
                        state_d = S_PIN;
                        pin_d   = card_pin;
                        bal_d   = card_balance;
                        tries_d = 4'(MAX_TRIES);
                    end
                end
                S_PIN: begin
                    if (pin_valid) begin
                        if (pin_input == pin_q) begin
                            state_d = S_MENU;
                        end else begin
                            tries_d = tries_q - 4'd1;
                            if (tries_q == 4'd1) state_d = S_LOCKED;
                        end
                    end
                end
                S_MENU: begin
                    if (exit)               state_d = S_EJECT;
                    else if (withdraw)      state_d = S_WITHDRAW;
                    else if (balance_check) state_d = S_BALANCE;
                end
                S_BALANCE: state_d = S_MENU;
                S_WITHDRAW: begin
                    if (exit) begin
                        state_d = S_EJECT;
                    end else if (amount_entered) begin
                        if (amount == '0 || amount > bal_q) begin
                            insuf_d = 1'b1;
                            state_d = S_MENU;
                        end else begin
                            amt_d   = amount;
                            state_d = S_DISPENSE;
                        end
                    end
                end
                S_DISPENSE: begin
                    if (cash_taken) begin
                        bal_d   = bal_q - amt_q;
                        state_d = S_MENU;
                    end
                end
                S_LOCKED: begin
                    // LOCK_CYCLES == 0 leaves the counter idle so only reset exits
                    if (LOCK_CYCLES != 0) begin
                        lock_d = lock_q + 1'b1;
                        if (lock_q == LW'(LOCK_CYCLES - 1)) state_d = S_IDLE;
                    end
                end
                S_EJECT: begin
                    pin_d   = '0;
                    bal_d   = '0;
                    amt_d   = '0;
                    tries_d = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (active && state_d == state_q && !strobe) idle_d = idle_q + 1'b1;
        end
    end

    assign state        = state_q;
    assign auth_success = state_q inside {S_MENU, S_BALANCE, S_WITHDRAW, S_DISPENSE};
    assign freeze       = (state_q == S_LOCKED);
    assign tries_left   = tries_q;
    assign balance      = bal_q;
    assign bal_valid    = (state_q == S_BALANCE);
    assign dispense     = (state_q == S_DISPENSE);
    assign dispense_amt = amt_q;
    assign insufficient = insuf_q;
    assign timeout      = tmo_q;

endmodule
